// File: rtl/fir_tap_sequencer_if.sv
// Configuration write port and coefficient tap stream between the sequencer
// (master) and its environment / the FIR tap loader (slave).
interface fir_tap_sequencer_if #(
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_TAP_WIDTH     = 16
);
    logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr;
    logic [G_TAP_WIDTH-1:0]     cfg_wr_data;
    logic                       cfg_wr_en;
    logic [G_TAP_WIDTH-1:0]     tap_dout;
    logic                       tap_dout_valid;
    logic                       tap_dout_ready;
    logic                       tap_done;

    modport master (
        input  cfg_wr_addr, cfg_wr_data, cfg_wr_en, tap_dout_ready, tap_done,
        output tap_dout, tap_dout_valid
    );

    modport slave (
        output cfg_wr_addr, cfg_wr_data, cfg_wr_en, tap_dout_ready, tap_done,
        input  tap_dout, tap_dout_valid
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Shadow coefficient RAM plus a commit sequencer that flushes the FIR, streams
// every tap in address order and waits for the FIR to acknowledge the load.
module fir_tap_sequencer #(
    parameter int G_NUM_TAPS_LOG2 = 4,
    parameter int G_TAP_WIDTH     = 16,
    parameter int G_DONE_TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_tap_sequencer_if.master  bus,
    input  logic                 commit,
    output logic                 busy,
    output logic                 loaded,
    output logic                 wr_dropped,
    output logic                 error,
    output logic                 fir_enable
);
    localparam int NT    = 2 ** G_NUM_TAPS_LOG2;
    localparam int CNT_W = G_NUM_TAPS_LOG2 + 1;
    localparam int TO_W  = (G_DONE_TIMEOUT > 1) ? $clog2(G_DONE_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, FLUSH, STREAM, WAIT_DONE, RUN} state_t;

    state_t                  state_q, state_d;
    logic                    flush_q, flush_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]        tx_cnt_q, tx_cnt_d;
    logic                    rvld_q, rvld_d;
    logic                    vld_q, vld_d;
    logic [G_TAP_WIDTH-1:0]  dout_q, dout_d;
    logic [G_TAP_WIDTH-1:0]  rdata_q;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    pending_q, pending_d;
    logic                    wr_drop_q, wr_drop_d;
    logic                    err_q, err_d;
    logic                    streaming, hs, load_out, issue, start;

    logic [G_TAP_WIDTH-1:0]  ram [NT];

    assign busy       = (state_q == FLUSH) || (state_q == STREAM) || (state_q == WAIT_DONE);
    assign loaded     = (state_q == RUN);
    assign fir_enable = (state_q == STREAM) || (state_q == WAIT_DONE) || (state_q == RUN);
    assign wr_dropped = wr_drop_q;
    assign error      = err_q;

    assign bus.tap_dout       = dout_q;
    assign bus.tap_dout_valid = vld_q;

    // Read word (rdata_q) acts as the skid slot behind the output register, so a
    // new read is only issued when that slot is empty or being drained this cycle.
    assign streaming = (state_q == FLUSH) || (state_q == STREAM);
    assign hs        = vld_q && bus.tap_dout_ready;
    assign load_out  = streaming && rvld_q && (!vld_q || bus.tap_dout_ready);
    assign issue     = streaming && (rd_cnt_q < CNT_W'(NT)) && (!rvld_q || load_out);

    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en && !busy) begin
            ram[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
        if (issue) begin
            rdata_q <= ram[rd_cnt_q[G_NUM_TAPS_LOG2-1:0]];
        end
    end

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        rd_cnt_d  = rd_cnt_q + CNT_W'(issue);
        tx_cnt_d  = tx_cnt_q + CNT_W'(hs);
        rvld_d    = issue || (rvld_q && !load_out);
        vld_d     = load_out || (vld_q && !hs);
        dout_d    = load_out ? rdata_q : dout_q;
        to_cnt_d  = to_cnt_q;
        pending_d = pending_q;
        wr_drop_d = wr_drop_q || (bus.cfg_wr_en && busy);
        err_d     = err_q;
        start     = 1'b0;

        case (state_q)
            IDLE: begin
                start = commit;
            end
            FLUSH: begin
                pending_d = pending_q || commit;
                flush_d   = 1'b1;
                if (flush_q) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                pending_d = pending_q || commit;
                if (hs && (tx_cnt_q == CNT_W'(NT - 1))) begin
                    state_d  = WAIT_DONE;
                    to_cnt_d = '0;
                end
            end
            WAIT_DONE: begin
                pending_d = pending_q || commit;
                if (bus.tap_done) begin
                    state_d = RUN;
                end else if (to_cnt_q == TO_W'(G_DONE_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RUN: begin
                start = commit || pending_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            state_d   = FLUSH;
            flush_d   = 1'b0;
            rd_cnt_d  = '0;
            tx_cnt_d  = '0;
            rvld_d    = 1'b0;
            vld_d     = 1'b0;
            pending_d = 1'b0;
            wr_drop_d = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            flush_q   <= 1'b0;
            rd_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            rvld_q    <= 1'b0;
            vld_q     <= 1'b0;
            dout_q    <= '0;
            to_cnt_q  <= '0;
            pending_q <= 1'b0;
            wr_drop_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            rd_cnt_q  <= rd_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            rvld_q    <= rvld_d;
            vld_q     <= vld_d;
            dout_q    <= dout_d;
            to_cnt_q  <= to_cnt_d;
            pending_q <= pending_d;
            wr_drop_q <= wr_drop_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: streaming, backpressure, dropped writes,
// done timeout, pending commit and mid-stream reset.
module tb_fir_tap_sequencer;
    logic clk, reset, commit;
    logic busy, loaded, wr_dropped, error, fir_enable;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] beats [16];
    int          nbeats, ncyc, hold_err, stall_err, stall_cycles;

    fir_tap_sequencer_if #(.G_NUM_TAPS_LOG2(4), .G_TAP_WIDTH(16)) bus ();

    fir_tap_sequencer #(.G_NUM_TAPS_LOG2(4), .G_TAP_WIDTH(16), .G_DONE_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .bus(bus), .commit(commit), .busy(busy), .loaded(loaded),
        .wr_dropped(wr_dropped), .error(error), .fir_enable(fir_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_commit;
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    // Called in the cycle after the last handshake; tap_done arrives 2 cycles after it.
    task automatic done_after2;
        step();
        bus.tap_done = 1'b1;
        step();
        bus.tap_done = 1'b0;
    endtask

    task automatic write_ram_default;
        for (int k = 0; k < 16; k++) begin
            bus.cfg_wr_en   = 1'b1;
            bus.cfg_wr_addr = 4'(k);
            bus.cfg_wr_data = 16'h0100 + 16'(k);
            step();
        end
        bus.cfg_wr_en = 1'b0;
    endtask

    // Starts in the first valid cycle; returns in the cycle after the 16th handshake.
    task automatic collect(input int mode, input int stall_beat, input int wr_cyc,
                           input logic [3:0] wr_a, input logic [15:0] wr_d, input int commit_cyc);
        logic        rdy, prev_stall;
        logic [15:0] prev_d;
        int          stall_left;
        nbeats = 0; ncyc = 0; hold_err = 0; stall_err = 0; stall_cycles = 0;
        prev_stall = 1'b0; prev_d = '0; stall_left = 5;
        for (int it = 0; it < 300; it++) begin
            rdy = (mode == 0) ? 1'b1 : ((it % 2) == 0);
            if (mode == 1 && nbeats == stall_beat && stall_left > 0 && bus.tap_dout_valid === 1'b1) begin
                rdy = 1'b0;
                stall_left--;
                stall_cycles++;
                if (bus.tap_dout !== 16'h0107) stall_err++;
            end
            bus.tap_dout_ready = rdy;
            bus.cfg_wr_en      = (it == wr_cyc);
            bus.cfg_wr_addr    = wr_a;
            bus.cfg_wr_data    = wr_d;
            commit             = (it == commit_cyc);
            if (prev_stall && (bus.tap_dout_valid !== 1'b1 || bus.tap_dout !== prev_d)) hold_err++;
            if (bus.tap_dout_valid === 1'b1 && rdy && nbeats < 16) begin
                beats[nbeats] = bus.tap_dout;
                nbeats++;
            end
            prev_stall = (bus.tap_dout_valid === 1'b1) && !rdy;
            prev_d     = bus.tap_dout;
            ncyc       = it + 1;
            step();
            if (nbeats == 16) break;
        end
        bus.tap_dout_ready = 1'b1;
        bus.cfg_wr_en      = 1'b0;
        commit             = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; commit = 1'b0;
        bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.tap_dout_ready = 1'b1; bus.tap_done = 1'b0;
        repeat (3) step();
        checks++;
        if ({fir_enable, bus.tap_dout_valid, busy, loaded, wr_dropped, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 000000",
                     {fir_enable, bus.tap_dout_valid, busy, loaded, wr_dropped, error});
        end
        checks++;
        if (bus.tap_dout !== 16'h0000) begin
            errors++; $display("FAIL reset_dout got %h required 0000", bus.tap_dout);
        end
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || loaded !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b loaded=%b required 0 0", busy, loaded);
        end
    endtask

    task automatic test_basic;
        write_ram_default();
        do_commit();
        checks++;
        if (busy !== 1'b1 || fir_enable !== 1'b0 || bus.tap_dout_valid !== 1'b0) begin
            errors++; $display("FAIL flush1 busy=%b en=%b vld=%b required 1 0 0", busy, fir_enable, bus.tap_dout_valid);
        end
        step();
        checks++;
        if (busy !== 1'b1 || fir_enable !== 1'b0 || bus.tap_dout_valid !== 1'b0) begin
            errors++; $display("FAIL flush2 busy=%b en=%b vld=%b required 1 0 0", busy, fir_enable, bus.tap_dout_valid);
        end
        step();
        checks++;
        if (bus.tap_dout_valid !== 1'b1 || bus.tap_dout !== 16'h0100 || fir_enable !== 1'b1) begin
            errors++; $display("FAIL first_beat vld=%b dout=%h en=%b required 1 0100 1", bus.tap_dout_valid, bus.tap_dout, fir_enable);
        end
        collect(0, -1, -1, 4'd0, 16'd0, -1);
        checks++;
        if (nbeats != 16 || ncyc != 16) begin
            errors++; $display("FAIL basic_count beats=%0d cycles=%0d required 16 16", nbeats, ncyc);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (beats[k] !== 16'h0100 + 16'(k)) begin
                errors++; $display("FAIL basic_beat%0d got %h required %h", k, beats[k], 16'h0100 + 16'(k));
            end
        end
        checks++;
        if (bus.tap_dout_valid !== 1'b0 || busy !== 1'b1 || loaded !== 1'b0) begin
            errors++; $display("FAIL wait_done vld=%b busy=%b loaded=%b required 0 1 0", bus.tap_dout_valid, busy, loaded);
        end
        done_after2();
        checks++;
        if (loaded !== 1'b1 || fir_enable !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_run loaded=%b en=%b busy=%b required 1 1 0", loaded, fir_enable, busy);
        end
    endtask

    task automatic test_backpressure;
        do_commit();
        checks++;
        if (loaded !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL recommit loaded=%b busy=%b required 0 1", loaded, busy);
        end
        step(); step();
        collect(1, 7, -1, 4'd0, 16'd0, -1);
        checks++;
        if (nbeats != 16) begin
            errors++; $display("FAIL bp_count got %0d required 16", nbeats);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (beats[k] !== 16'h0100 + 16'(k)) begin
                errors++; $display("FAIL bp_beat%0d got %h required %h", k, beats[k], 16'h0100 + 16'(k));
            end
        end
        checks++;
        if (hold_err != 0 || stall_err != 0 || stall_cycles != 5) begin
            errors++; $display("FAIL bp_hold hold_err=%0d stall_err=%0d stall=%0d required 0 0 5", hold_err, stall_err, stall_cycles);
        end
        done_after2();
        checks++;
        if (loaded !== 1'b1) begin
            errors++; $display("FAIL bp_run loaded=%b required 1", loaded);
        end
    endtask

    task automatic test_wr_dropped;
        do_commit();
        step(); step();
        collect(0, -1, 0, 4'd3, 16'h7FFF, -1);
        checks++;
        if (wr_dropped !== 1'b1) begin
            errors++; $display("FAIL wr_dropped_set got %b required 1", wr_dropped);
        end
        checks++;
        if (beats[3] !== 16'h0103) begin
            errors++; $display("FAIL dropped_beat3 got %h required 0103", beats[3]);
        end
        done_after2();
        checks++;
        if (loaded !== 1'b1 || wr_dropped !== 1'b1) begin
            errors++; $display("FAIL sticky_drop loaded=%b drop=%b required 1 1", loaded, wr_dropped);
        end
        commit = 1'b1; bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 4'd5; bus.cfg_wr_data = 16'h5555;
        step();
        commit = 1'b0; bus.cfg_wr_en = 1'b0;
        checks++;
        if (wr_dropped !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL drop_clear drop=%b busy=%b required 0 1", wr_dropped, busy);
        end
        step(); step();
        collect(0, -1, -1, 4'd0, 16'd0, -1);
        checks++;
        if (nbeats != 16 || beats[5] !== 16'h5555 || beats[3] !== 16'h0103) begin
            errors++; $display("FAIL wr_with_commit beats=%0d b5=%h b3=%h required 16 5555 0103", nbeats, beats[5], beats[3]);
        end
        done_after2();
        bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 4'd5; bus.cfg_wr_data = 16'h0105;
        step();
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic test_timeout;
        int k;
        do_commit();
        step(); step();
        collect(0, -1, -1, 4'd0, 16'd0, 3);
        checks++;
        if (fir_enable !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL to_wait en=%b err=%b required 1 0", fir_enable, error);
        end
        k = 0;
        while (error !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (k != 15) begin
            errors++; $display("FAIL timeout_cycles got %0d required 15", k);
        end
        checks++;
        if (fir_enable !== 1'b0 || loaded !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_idle en=%b loaded=%b busy=%b required 0 0 0", fir_enable, loaded, busy);
        end
        step(); step();
        checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            errors++; $display("FAIL pending_discard busy=%b err=%b required 0 1", busy, error);
        end
    endtask

    task automatic test_pending;
        do_commit();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL err_clear err=%b busy=%b required 0 1", error, busy);
        end
        step(); step();
        collect(0, -1, -1, 4'd0, 16'd0, 4);
        done_after2();
        checks++;
        if (loaded !== 1'b1) begin
            errors++; $display("FAIL pend_run loaded=%b required 1", loaded);
        end
        step();
        checks++;
        if (loaded !== 1'b0 || busy !== 1'b1 || fir_enable !== 1'b0) begin
            errors++; $display("FAIL pend_reflush loaded=%b busy=%b en=%b required 0 1 0", loaded, busy, fir_enable);
        end
        step(); step();
        checks++;
        if (bus.tap_dout_valid !== 1'b1 || bus.tap_dout !== 16'h0100) begin
            errors++; $display("FAIL pend_first vld=%b dout=%h required 1 0100", bus.tap_dout_valid, bus.tap_dout);
        end
        collect(0, -1, -1, 4'd0, 16'd0, -1);
        checks++;
        if (nbeats != 16 || beats[0] !== 16'h0100 || beats[15] !== 16'h010F) begin
            errors++; $display("FAIL pend_stream beats=%0d b0=%h b15=%h required 16 0100 010F", nbeats, beats[0], beats[15]);
        end
        done_after2();
        step(); step();
        checks++;
        if (loaded !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL pend_cleared loaded=%b busy=%b required 1 0", loaded, busy);
        end
    endtask

    task automatic test_reset_midstream;
        int n;
        do_commit();
        step(); step();
        bus.tap_dout_ready = 1'b1;
        n = 0;
        while (bus.tap_dout !== 16'h0109 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus.tap_dout !== 16'h0109 || bus.tap_dout_valid !== 1'b1) begin
            errors++; $display("FAIL reach_beat9 dout=%h vld=%b required 0109 1", bus.tap_dout, bus.tap_dout_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({fir_enable, bus.tap_dout_valid, busy, loaded, wr_dropped, error} !== 6'b0 || bus.tap_dout !== 16'h0000) begin
            errors++; $display("FAIL midreset flags=%b dout=%h required 000000 0000",
                               {fir_enable, bus.tap_dout_valid, busy, loaded, wr_dropped, error}, bus.tap_dout);
        end
        step();
        do_commit();
        step(); step();
        collect(0, -1, -1, 4'd0, 16'd0, -1);
        checks++;
        if (nbeats != 16) begin
            errors++; $display("FAIL after_reset_count got %0d required 16", nbeats);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (beats[k] !== 16'h0100 + 16'(k)) begin
                errors++; $display("FAIL after_reset_beat%0d got %h required %h", k, beats[k], 16'h0100 + 16'(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wr_dropped();
        test_timeout();
        test_pending();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Upstream control stage for the configurable FIR. Holds a shadow coefficient RAM written over a simple register-style write port.
- On a commit request it restarts the FIR by dropping its enable, then streams all coefficients in address order over a valid/ready tap interface.
- It waits for the FIR's tap-done indication, then re-enables filtering and reports the loaded status.

Parameters:
- G_NUM_TAPS_LOG2, 4, log2 of the total tap count (NT = 2**G_NUM_TAPS_LOG2). Must equal the FIR's NUM_STAGES_LOG2 + STAGE_DEPTH_LOG2.
- G_TAP_WIDTH, 16, coefficient width in bits.
- G_DONE_TIMEOUT, 15, maximum cycles allowed between the last accepted tap beat and tap_done; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_wr_addr  in  G_NUM_TAPS_LOG2  shadow RAM write address
- cfg_wr_data  in  G_TAP_WIDTH  coefficient value
- cfg_wr_en  in  1  write strobe, one write per cycle
- commit  in  1  single-cycle request to load the shadow RAM into the FIR
- busy  out  1  high while in FLUSH, STREAM or WAIT_DONE
- loaded  out  1  high in RUN; the FIR holds the committed taps
- wr_dropped  out  1  sticky: a cfg write arrived while busy
- error  out  1  sticky: tap_done timeout
- fir_enable  out  1  drives the FIR enable input
- tap_dout  out  G_TAP_WIDTH  coefficient to the FIR tap_din
- tap_dout_valid  out  1  coefficient valid
- tap_dout_ready  in  1  from the FIR tap_din_ready
- tap_done  in  1  from the FIR tap_din_done

Behaviour:
- Reset values:
  - All outputs are 0: fir_enable=0, tap_dout_valid=0, tap_dout=0, busy=0, loaded=0, wr_dropped=0, error=0.
  - State goes to IDLE. Shadow RAM contents are not reset.
- Shadow RAM:
  - NT x G_TAP_WIDTH, one write port and one read port, 1-cycle registered read.
  - A write takes effect when cfg_wr_en=1 and busy=0.
  - When cfg_wr_en=1 and busy=1, the RAM is unchanged and wr_dropped is set.
  - wr_dropped and error clear only on reset or on an accepted commit.
- States:
  - IDLE:
    - fir_enable=0.
    - commit=1 -> FLUSH; clears error and wr_dropped.
  - FLUSH:
    - fir_enable=0 for exactly 2 cycles, so the FIR returns to its init state and its tap_done falls.
    - During FLUSH, reads are issued from address 0. Read address counter rd_cnt width is G_NUM_TAPS_LOG2+1.
    - Then -> STREAM, with fir_enable=1 from the first STREAM cycle onward.
  - STREAM:
    - Follows AXI-stream rules. tap_dout and tap_dout_valid are registered.
    - Once valid rises, tap_dout is held stable until tap_dout_valid && tap_dout_ready.
    - Beat k carries RAM[k], k = 0..NT-1, with no gaps, duplicates or reordering under any ready pattern.
    - Prefetch or skid is required so that continuous ready gives one beat per cycle.
    - After the handshake of beat NT-1, tap_dout_valid=0 the next cycle -> WAIT_DONE, and the timeout counter loads 0.
  - WAIT_DONE:
    - tap_done=1 -> RUN.
    - Otherwise the counter increments each cycle.
    - When the counter reaches G_DONE_TIMEOUT with no tap_done, set error=1, drive fir_enable=0 and go to IDLE.
  - RUN:
    - loaded=1, fir_enable=1.
    - commit=1 -> FLUSH; loaded falls the next cycle.
- Commit outside IDLE/RUN:
  - commit during FLUSH, STREAM or WAIT_DONE sets a one-deep pending flag.
  - On entering RUN with pending=1, the block goes straight to FLUSH, spending one cycle in RUN with loaded=1, and pending clears.
  - A pending commit is discarded if a timeout sends the block to IDLE.
- Simultaneous events:
  - cfg_wr_en together with commit in IDLE/RUN: the write is applied (busy is 0 that cycle) and the stream includes the new value.
- Latency: commit at cycle 0 gives FLUSH in cycles 1-2, and tap_dout_valid=1 at cycle 3 carrying RAM[0].
- tap_done ignored: any tap_done seen in FLUSH or STREAM is ignored.
- Reset mid-stream: everything returns to reset values next cycle. fir_enable=0 restarts the FIR, so no partial-load state survives.

Test Plan:
- Write RAM[k]=16'h0100+k for k=0..15, commit, tap_dout_ready=1 constant -> valid rises 3 cycles after commit; 16 consecutive beats 0100..010F; tap_done at +2 cycles -> loaded=1, fir_enable=1.
- Same load, ready toggling 1010 pattern plus one 5-cycle stall at beat 7 -> tap_dout holds 0107 through the stall; exactly 16 beats in order; no duplicates.
- cfg_wr_en (addr 3, data 7FFF) during STREAM -> wr_dropped=1; the streamed beat 3 keeps the old value; the next commit clears wr_dropped.
- tap_done held 0 after the last beat -> error=1 exactly 15 cycles after the last handshake; fir_enable=0; state IDLE; loaded=0.
- commit pulsed during STREAM -> after loaded rises for 1 cycle, the sequencer re-flushes and a second full 16-beat stream follows.
- reset asserted at beat 9 -> all outputs 0 next cycle; a fresh commit streams from RAM[0] with the RAM contents preserved.
